// File: rtl/fsm_core.sv
// Purpose: serial pattern detector; flags each (overlapping) occurrence of PATTERN in the bit stream.
// Latency: out rises in the cycle after the edge that samples the final pattern bit (Moore decode of st).
// Backpressure: none; one bit of `in` is consumed on every rising clk edge.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous active-low reset; clears st (and hit_cnt)
//   in       in   1      serial data bit, first pattern bit = PATTERN[PAT_LEN-1]
//   out      out  1      high for one cycle per completed match
//   hit_cnt  out  CNT_W  saturating match count (only with FSM_HIT_CNT_EN defined)
//
// Build option: define FSM_HIT_CNT_EN to add the hit_cnt port and its counter.
`timescale 1ns/1ps

module fsm_core #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    output logic             out
`ifdef FSM_HIT_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    localparam int             SW      = $clog2(PAT_LEN + 1);
    localparam logic [SW-1:0]  ST_FULL = SW'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : g_bad_param
        $error("fsm_core: PAT_LEN must be 2..16 and CNT_W >= 1");
    end

    // Pattern bit i in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input int i);
        logic [PAT_LEN-1:0] t;
        t = PATTERN >> (PAT_LEN - 1 - i);
        return t[0];
    endfunction

    // Longest pattern prefix that is a suffix of (prefix(k) followed by b).
    // At k == PAT_LEN the full pattern is the starting string, which is what
    // lets consecutive matches overlap.
    function automatic int kmp_next(input int k, input logic b);
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            if (j <= k + 1) begin
                ok = (b == pat_bit(j - 1));
                for (int m = 0; m < j - 1; m++) begin
                    if (pat_bit(k + 1 - j + m) != pat_bit(m)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    // st holds the matched prefix length k (states S0..S(PAT_LEN)). The state
    // count follows PAT_LEN, so it is a plain vector rather than an enum.
    logic [SW-1:0] st;
    logic [SW-1:0] st_next;

    // Transition table for in=0 / in=1, evaluated from PATTERN at elaboration.
    logic [SW-1:0] nxt0 [PAT_LEN+1];
    logic [SW-1:0] nxt1 [PAT_LEN+1];

    for (genvar g = 0; g <= PAT_LEN; g++) begin : g_tbl
        localparam int N0 = kmp_next(g, 1'b0);
        localparam int N1 = kmp_next(g, 1'b1);
        assign nxt0[g] = SW'(N0);
        assign nxt1[g] = SW'(N1);
    end

    always_comb begin
        st_next = '0;
        // Encodings above PAT_LEN are unreachable; they fall back to S0.
        if (st <= ST_FULL) begin
            st_next = in ? nxt1[st] : nxt0[st];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= '0;
        end else begin
            st <= st_next;
        end
    end

    assign out = (st == ST_FULL);

`ifdef FSM_HIT_CNT_EN
    // Counts on the edge that enters S(PAT_LEN), so it moves together with out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt <= '0;
        end else if (st_next == ST_FULL && hit_cnt != '1) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end
`else
    // Counter build option disabled: only the match flag is produced.
`endif

endmodule

// File: tb/tb_fsm_core.sv
`timescale 1ns/1ps

module tb_fsm_core;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       din   = 1'b0;
    logic       dout;
`ifdef FSM_HIT_CNT_EN
    logic [7:0] hit_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fsm_core #(
        .PAT_LEN (4),
        .PATTERN (4'b1011),
        .CNT_W   (8)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .in      (din),
        .out     (dout)
`ifdef FSM_HIT_CNT_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one bit, clock it in, and check out just after the edge.
    task automatic step(input logic b, input logic exp_out, input string tag);
        din = b;
        @(posedge clk);
        #1;
        check(tag, {31'b0, dout}, {31'b0, exp_out});
    endtask

    // bits/outs are listed MSB first in arrival order, n entries.
    task automatic run_seq(input logic [15:0] bits, input logic [15:0] outs,
                           input int n, input string name);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], outs[i], $sformatf("%s[%0d]", name, n - 1 - i));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] hist;
        int         nbits;
        logic       b;
        void'($urandom(32'd12345));

        // 1. Reset held for 3 edges, then 20 zeros.
        rst_n = 1'b0;
        #1;
        check("rst_async_out", {31'b0, dout}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold_out[%0d]", i), {31'b0, dout}, 32'd0);
            check($sformatf("rst_hold_st[%0d]", i), 32'(dut.st), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, $sformatf("zeros[%0d]", i));
        end
        check("zeros_st", 32'(dut.st), 32'd0);

        // 2. Single match, then a 0 drops out.
        do_reset();
        run_seq(16'b10110, 16'b00010, 5, "single");

        // 3. Overlapping matches.
        do_reset();
        run_seq(16'b1011011, 16'b0001001, 7, "overlap");

        // 4. S3 + 0 falls back to S2.
        do_reset();
        run_seq(16'b101011, 16'b000001, 6, "fallback");

        // 5. Reset mid-sequence discards the partial match.
        do_reset();
        run_seq(16'b101, 16'b000, 3, "partial");
        check("partial_st", 32'(dut.st), 32'd3);
        rst_n = 1'b0;
        #2;
        check("midrst_st", 32'(dut.st), 32'd0);
        check("midrst_out", {31'b0, dout}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_hold_st", 32'(dut.st), 32'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, "after_rst");
        check("after_rst_st", 32'(dut.st), 32'd1);

        // Asynchronous clear while out is high.
        do_reset();
        run_seq(16'b1011, 16'b0001, 4, "pre_async");
        rst_n = 1'b0;
        #1;
        check("async_clr_out", {31'b0, dout}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef FSM_HIT_CNT_EN
        // 6. Hit counter: disjoint matches, saturation, async clear.
        do_reset();
        check("cnt_rst", 32'(hit_cnt), 32'd0);
        run_seq(16'b10110101101011, 16'b00010000100001, 14, "disjoint");
        check("cnt_disjoint", 32'(hit_cnt), 32'd3);
        do_reset();
        run_seq(16'b1011, 16'b0001, 4, "sat_first");
        for (int i = 1; i < 300; i++) begin
            step(1'b0, 1'b0, "sat_a");
            step(1'b1, 1'b0, "sat_b");
            step(1'b1, 1'b1, "sat_c");
            if (i == 199) begin
                check("cnt_200", 32'(hit_cnt), 32'd200);
            end
        end
        check("cnt_sat", 32'(hit_cnt), 32'd255);
        run_seq(16'b011, 16'b001, 3, "sat_more");
        check("cnt_sat_hold", 32'(hit_cnt), 32'd255);
        rst_n = 1'b0;
        #1;
        check("cnt_async_clr", 32'(hit_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif

        // Seeded random stream against a shift-register reference.
        do_reset();
        hist  = 4'b0000;
        nbits = 0;
        for (int c = 0; c < 1000; c++) begin
            b   = 1'($urandom_range(0, 1));
            din = b;
            @(posedge clk);
            hist  = {hist[2:0], b};
            nbits = nbits + 1;
            #1;
            if (c >= 10) begin
                check($sformatf("rand[%0d]", c), {31'b0, dout},
                      {31'b0, (nbits >= 4 && hist == 4'b1011)});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
